mips_timer: RTL and testbench
=============================

// Module: mips_timer
// PURPOSE
//  Memory-mapped down-counter timer sitting directly downstream of the system bridge (two instances: 0x7F00, 0x7F10).
//  Bridge supplies full byte address, write enable, write data; timer returns combinational read data.
//  Counts PRESET down to 0, then raises an interrupt request to the CPU's external-interrupt input.
//  Two modes: one-shot (mode 0) and auto-reload (mode 1).
// PARAMETERS
//  WIDTH  32  width of PRESET/COUNT registers; values zero-extended to 32 bits on rd
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  reset_n  in   1   asynchronous reset, active-low
//  addr     in   32  byte address from bridge; only addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//  we       in   1   write strobe; already qualified by bridge address select
//  wd       in   32  write data
//  rd       out  32  read data, combinational on addr[3:2]
//  irq      out  1   interrupt request, level, = CTRL.IM & irq_pend
// BEHAVIOUR
//  Registers: CTRL[3:0] = {IM, MODE[1:0], EN}, bits [31:4] read 0; PRESET[WIDTH-1:0] r/w; COUNT read-only.
//  Reset (reset_n low, async): CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE; rd reflects zeros, irq=0.
//  Writes: we&addr[3:2]==0 -> CTRL<=wd[3:0]; ==1 -> PRESET<=wd[WIDTH-1:0]; ==2,3 ignored. Take effect next edge.
//  CPU write to CTRL wins over any same-cycle FSM update of CTRL.EN.
//  MODE 2'b00 one-shot, 2'b01 auto-reload; 2'b10/2'b11 behave as one-shot.
//  FSM (one transition per clk):
//   IDLE: if CTRL.EN -> LOAD, irq_pend<=0.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT : if !CTRL.EN -> IDLE (COUNT frozen). elif COUNT>1 -> COUNT<=COUNT-1.
//         else COUNT<=0, irq_pend<=1 -> INT.
//   INT : one-shot: CTRL.EN<=0 (unless CPU writes CTRL this cycle), irq_pend held -> IDLE.
//         auto-reload: irq_pend<=0 -> IDLE (so irq is a 1-cycle pulse; EN stays 1, reload follows).
//  Latency: EN written at edge 0 -> LOAD at 1 -> COUNT=PRESET at 2 -> irq_pend at edge 2+PRESET (PRESET>=1).
//  PRESET=0: LOAD gives COUNT=0; CNT sees COUNT<=1 next cycle -> INT; same as PRESET=1.
//  PRESET write while counting: no effect on COUNT until next LOAD.
//  One-shot irq_pend clears only when CPU re-arms (EN=1 -> IDLE clears it) or reset; clearing IM masks irq only.
//  Auto-reload period = PRESET+3 cycles (LOAD, PRESET counts, INT, IDLE).
//  COUNT never wraps below 0; no underflow path.
//  reset_n asserted mid-count: immediate return to reset values, irq deasserts asynchronously.
//  Reads have no side effects; reserved offset reads 0.
// TESTING
//  Reset: reset_n=0 mid-count -> rd CTRL/PRESET/COUNT all 0, irq=0 same cycle.
//  One-shot: PRESET=5, CTRL=4'b1001 -> COUNT 5,4,3,2,1,0; irq=1 at edge 7 after write; CTRL reads 4'b1000; irq stays 1.
//  Re-arm: after one-shot, write CTRL=4'b1001 -> irq drops next edge, new countdown from PRESET.
//  Auto-reload: PRESET=3, CTRL=4'b1011 -> irq 1-cycle pulses every 6 cycles, EN stays 1, for >=3 periods.
//  Mask/stop: IM=0 -> irq stays 0 while irq_pend set; EN cleared mid-count at COUNT=2 -> COUNT holds 2, no irq.
//  Write rules: write 0x1234 to COUNT -> ignored; PRESET=0 -> irq same timing as PRESET=1; rd at addr 0x7F0C = 0.

Source files
------------

// File: rtl/mips_timer.sv
// Memory-mapped down-counter timer. Three registers are decoded from addr[3:2]:
// CTRL {IM, MODE[1:0], EN}, PRESET (read/write) and COUNT (read-only).
// COUNT loads from PRESET and counts down to 0, then sets a pending interrupt.
// MODE 2'b01 reloads automatically; every other MODE value stops after one count.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for CTRL.EN; arming clears the pending interrupt
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT; leaving at COUNT<=1 sets the pending interrupt
// INT   | one-shot: drop EN, keep the interrupt pending; auto: drop pending
module mips_timer #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  state_t             state_q, state_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   preset_q, preset_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               irq_pend_q, irq_pend_d;

  logic               ctrl_en;
  logic               ctrl_im;
  logic               mode_auto;
  logic               fsm_clr_en;
  logic               unused_bits;

  assign ctrl_en   = ctrl_q[0];
  assign ctrl_im   = ctrl_q[3];
  assign mode_auto = (ctrl_q[2:1] == 2'b01);

  // Only addr[3:2] is decoded; the rest of the bus is ignored on purpose.
  assign unused_bits = ^{addr[31:4], addr[1:0], wd};

  // State and register file flops; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // Next-state logic: FSM first, then CPU writes so a CTRL write overrides
  // the one-shot EN clear issued in the same cycle.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;
    fsm_clr_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_en) begin
          state_d    = S_LOAD;
          irq_pend_d = 1'b0;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d    = '0;
          irq_pend_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (mode_auto) begin
          irq_pend_d = 1'b0;
        end else begin
          fsm_clr_en = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fsm_clr_en) begin
      ctrl_d[0] = 1'b0;
    end

    if (we && (addr[3:2] == OFS_CTRL)) begin
      ctrl_d = wd[3:0];
    end
    if (we && (addr[3:2] == OFS_PRESET)) begin
      preset_d = wd[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended; the reserved offset reads as zero.
  always_comb begin
    rd = 32'd0;
    case (addr[3:2])
      OFS_CTRL:   rd = {28'd0, ctrl_q};
      OFS_PRESET: rd = 32'(preset_q);
      OFS_COUNT:  rd = 32'(count_q);
      default:    rd = 32'd0;
    endcase
  end

  assign irq = ctrl_im & irq_pend_q;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: reset, one-shot, re-arm, mask, stop,
// register write rules, auto-reload pulse train, PRESET=0 and async reset.
module tb_mips_timer;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  mips_timer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  logic [31:0] v;
  logic [31:0] exp_cnt;
  logic        exp_irq;

  initial begin
    reset_n = 1'b0;
    addr    = 32'd0;
    we      = 1'b0;
    wd      = 32'd0;
    #2;
    reg_rd(A_CTRL, v);   check("rst_ctrl", v, 32'd0);
    reg_rd(A_PRESET, v); check("rst_preset", v, 32'd0);
    reg_rd(A_COUNT, v);  check("rst_count", v, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    #10;
    reset_n = 1'b1;
    tick();

    // One-shot, PRESET=5: COUNT=5 after edge 2, irq after edge 7.
    reg_wr(A_PRESET, 32'd5);
    reg_wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1 || k == 8) exp_cnt = 32'd0;
      else exp_cnt = 32'(7 - k);
      exp_irq = (k >= 7);
      reg_rd(A_COUNT, v);
      check($sformatf("os_count_k%0d", k), v, exp_cnt);
      check($sformatf("os_irq_k%0d", k), {31'd0, irq}, {31'd0, exp_irq});
    end
    reg_rd(A_CTRL, v); check("os_ctrl_after", v, 32'h8);
    tick(); tick();
    check("os_irq_held", {31'd0, irq}, 32'd1);

    // Re-arm: irq drops one edge after the CTRL write, new countdown follows.
    reg_wr(A_CTRL, 32'h9);
    check("rearm_irq_e0", {31'd0, irq}, 32'd1);
    tick();
    check("rearm_irq_e1", {31'd0, irq}, 32'd0);
    tick();
    reg_rd(A_COUNT, v); check("rearm_count_e2", v, 32'd5);
    tick(); tick(); tick(); tick();
    reg_rd(A_COUNT, v); check("rearm_count_e6", v, 32'd1);
    check("rearm_irq_e6", {31'd0, irq}, 32'd0);
    tick();
    check("rearm_irq_e7", {31'd0, irq}, 32'd1);
    tick();

    // Mask: IM=0 hides the pending interrupt, IM=1 shows it again.
    reg_wr(A_CTRL, 32'h0);
    check("mask_irq_off", {31'd0, irq}, 32'd0);
    tick();
    check("mask_irq_off2", {31'd0, irq}, 32'd0);
    reg_wr(A_CTRL, 32'h8);
    check("mask_irq_on", {31'd0, irq}, 32'd1);

    // Stop mid-count: EN cleared on the edge where COUNT becomes 2.
    reg_wr(A_CTRL, 32'h9);
    tick(); tick(); tick(); tick();
    reg_rd(A_COUNT, v); check("stop_count_3", v, 32'd3);
    reg_wr(A_CTRL, 32'h8);
    reg_rd(A_COUNT, v); check("stop_count_2", v, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    reg_rd(A_COUNT, v); check("stop_count_hold", v, 32'd2);
    check("stop_irq", {31'd0, irq}, 32'd0);

    // Write rules, using the second instance's base address.
    reg_wr(32'h0000_7F18, 32'h1234);
    reg_rd(A_COUNT, v); check("wr_count_ignored", v, 32'd2);
    reg_wr(32'h0000_7F1C, 32'hFFFF_FFFF);
    reg_rd(32'h0000_7F10, v); check("wr_rsvd_ctrl", v, 32'h8);
    reg_rd(32'h0000_7F14, v); check("wr_rsvd_preset", v, 32'd5);
    reg_rd(A_RSVD, v);        check("rd_rsvd", v, 32'd0);
    reg_wr(A_PRESET, 32'hDEAD_BEEF);
    reg_rd(A_PRESET, v);      check("preset_full", v, 32'hDEAD_BEEF);

    // Auto-reload, PRESET=3: irq pulses after edges 5, 11, 17.
    reg_wr(A_PRESET, 32'd3);
    reg_wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_irq = (k >= 5) && (((k - 5) % 6) == 0);
      check($sformatf("ar_irq_k%0d", k), {31'd0, irq}, {31'd0, exp_irq});
      if (k >= 2) begin
        case ((k - 2) % 6)
          0: exp_cnt = 32'd3;
          1: exp_cnt = 32'd2;
          2: exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        reg_rd(A_COUNT, v);
        check($sformatf("ar_count_k%0d", k), v, exp_cnt);
      end
      if (k == 6 || k == 18) begin
        reg_rd(A_CTRL, v);
        check($sformatf("ar_ctrl_k%0d", k), v, 32'hB);
      end
    end
    reg_wr(A_CTRL, 32'h0);
    tick(); tick();

    // PRESET=0 behaves like PRESET=1: irq after edge 3.
    reg_wr(A_PRESET, 32'd0);
    reg_wr(A_CTRL, 32'h9);
    tick();
    check("p0_irq_k1", {31'd0, irq}, 32'd0);
    tick();
    check("p0_irq_k2", {31'd0, irq}, 32'd0);
    reg_rd(A_COUNT, v); check("p0_count_k2", v, 32'd0);
    tick();
    check("p0_irq_k3", {31'd0, irq}, 32'd1);
    tick();
    reg_rd(A_CTRL, v); check("p0_ctrl_k4", v, 32'h8);

    // Async reset in the middle of a countdown.
    reg_wr(A_PRESET, 32'd9);
    reg_wr(A_CTRL, 32'h9);
    tick(); tick(); tick(); tick();
    reg_rd(A_COUNT, v); check("mid_count_7", v, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    reg_rd(A_CTRL, v);   check("arst_ctrl", v, 32'd0);
    reg_rd(A_PRESET, v); check("arst_preset", v, 32'd0);
    reg_rd(A_COUNT, v);  check("arst_count", v, 32'd0);
    #1;
    reset_n = 1'b1;
    tick(); tick(); tick();
    reg_rd(A_COUNT, v); check("post_rst_count", v, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
